// File: rtl/pid_error_frontend.sv
// Front end of the laser-loop PI controller. It averages ADC power-monitor
// samples, subtracts the average from a setpoint, then scales and clips the
// result into a 9-bit signed error word.
module pid_error_frontend #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 2,
  parameter int SHIFT    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] setpoint,
  input  logic             setpoint_load,
  output logic [8:0]       e_out,
  output logic             e_valid,
  output logic             sat_flag,
  output logic             overrun,
  output logic             busy
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0]        LAST  = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic signed [ADC_W:0]   E_MAX = (ADC_W+1)'(255);
  localparam logic signed [ADC_W:0]   E_MIN = (ADC_W+1)'(-256);

  typedef enum logic [1:0] {ACCUM, COMPUTE, EMIT} state_t;

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADC_W-1:0]  setpoint_q, setpoint_d;
  logic [8:0]        e_out_q, e_out_d;
  logic              sat_q, sat_d;
  logic              overrun_q, overrun_d;

  logic [ADC_W-1:0]  avg;
  logic signed [ADC_W:0] diff, scaled;
  logic [8:0]        e_clip;
  logic              clip;

  // Error datapath; only sampled into e_out_q during COMPUTE.
  always_comb begin
    avg    = acc_q[ACC_W-1:AVG_LOG2];
    diff   = $signed({1'b0, setpoint_q}) - $signed({1'b0, avg});
    scaled = diff >>> SHIFT;
    clip   = 1'b0;
    e_clip = scaled[8:0];
    if (scaled > E_MAX) begin
      clip   = 1'b1;
      e_clip = 9'h0FF;
    end else if (scaled < E_MIN) begin
      clip   = 1'b1;
      e_clip = 9'h100;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    e_out_d    = e_out_q;
    sat_d      = sat_q;
    setpoint_d = setpoint_load ? setpoint : setpoint_q;
    // Samples landing in COMPUTE/EMIT are lost; remember that it happened.
    overrun_d  = overrun_q | (adc_valid && (state_q != ACCUM));
    case (state_q)
      ACCUM: begin
        if (adc_valid) begin
          acc_d = acc_q + ACC_W'(adc_data);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        e_out_d = e_clip;
        sat_d   = clip;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = EMIT;
      end
      EMIT:    state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      setpoint_q <= '0;
      e_out_q    <= '0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      setpoint_q <= setpoint_d;
      e_out_q    <= e_out_d;
      sat_q      <= sat_d;
      overrun_q  <= overrun_d;
    end
  end

  assign e_out    = e_out_q;
  assign sat_flag = sat_q;
  assign overrun  = overrun_q;
  assign e_valid  = (state_q == EMIT);
  assign busy     = (state_q != ACCUM);

endmodule

// File: tb/tb_pid_error_frontend.sv
// Directed bench for pid_error_frontend: hand-computed error words, latency,
// saturation, overrun and mid-frame reset.
module tb_pid_error_frontend;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic [11:0] setpoint;
  logic        setpoint_load;
  logic [8:0]  e_out;
  logic        e_valid;
  logic        sat_flag;
  logic        overrun;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int ev_count = 0;

  pid_error_frontend #(.ADC_W(12), .AVG_LOG2(2), .SHIFT(3)) dut (
    .clk(clk), .reset(reset),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .setpoint(setpoint), .setpoint_load(setpoint_load),
    .e_out(e_out), .e_valid(e_valid), .sat_flag(sat_flag),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (e_valid) ev_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load_sp(input int v);
    setpoint      = v[11:0];
    setpoint_load = 1'b1;
    tick();
    setpoint_load = 1'b0;
  endtask

  task automatic send(input int v);
    adc_data  = v[11:0];
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  // Four samples at 4-cycle spacing, then check the COMPUTE/EMIT timing.
  // sp_cmp >= 0 loads that setpoint during the COMPUTE cycle.
  task automatic frame(input string tag, input int s0, input int s1,
                       input int s2, input int s3, input int exp_e,
                       input int exp_sat, input int sp_cmp);
    int s[4];
    int ev0;
    s   = '{s0, s1, s2, s3};
    ev0 = ev_count;
    for (int i = 0; i < 4; i++) begin
      send(s[i]);
      if (i < 3) repeat (3) tick();
    end
    chk({tag, "_no_early_ev"}, ev_count - ev0, 0);
    chk({tag, "_cmp_busy"}, busy, 1);
    chk({tag, "_cmp_ev"}, e_valid, 0);
    if (sp_cmp >= 0) begin
      setpoint      = sp_cmp[11:0];
      setpoint_load = 1'b1;
    end
    tick();
    setpoint_load = 1'b0;
    chk({tag, "_ev"}, e_valid, 1);
    chk({tag, "_e"}, $signed(e_out), exp_e);
    chk({tag, "_sat"}, sat_flag, exp_sat);
    chk({tag, "_emit_busy"}, busy, 1);
    tick();
    chk({tag, "_ev_off"}, e_valid, 0);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_e_hold"}, $signed(e_out), exp_e);
    tick();
    chk({tag, "_ev_once"}, ev_count - ev0, 1);
  endtask

  initial begin
    reset = 1'b1; adc_data = '0; adc_valid = 1'b0;
    setpoint = '0; setpoint_load = 1'b0;
    repeat (3) tick();
    chk("rst_e", e_out, 0);
    chk("rst_ev", e_valid, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    load_sp(2048);
    frame("basic", 2000, 2000, 2000, 2000, 6, 0, -1);
    frame("floor_avg", 1000, 1001, 1002, 1003, 130, 0, -1);

    load_sp(4095);
    frame("sat_pos", 0, 0, 0, 0, 255, 1, -1);
    load_sp(0);
    frame("sat_neg", 4095, 4095, 4095, 4095, -256, 1, -1);
    load_sp(2048);
    frame("zero", 2048, 2048, 2048, 2048, 0, 0, -1);

    load_sp(2000);
    frame("neg_floor", 2001, 2001, 2001, 2001, -1, 0, -1);
    chk("neg_floor_raw", e_out, 9'h1FF);

    // Setpoint loaded in COMPUTE must only affect the following frame.
    load_sp(2048);
    frame("ld_in_cmp", 2000, 2000, 2000, 2000, 6, 0, 0);
    frame("ld_next", 2000, 2000, 2000, 2000, -250, 0, -1);
    chk("no_ovr_yet", overrun, 0);

    // Overrun: fifth strobe lands in COMPUTE and must be dropped.
    load_sp(2048);
    for (int i = 0; i < 4; i++) begin
      send(2000);
      if (i < 3) repeat (3) tick();
    end
    adc_data  = 12'd0;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    chk("ovr_set", overrun, 1);
    chk("ovr_ev", e_valid, 1);
    chk("ovr_e", $signed(e_out), 6);
    repeat (3) tick();
    frame("ovr_next", 2000, 2000, 2000, 2000, 6, 0, -1);
    chk("ovr_sticky", overrun, 1);

    // Reset mid-frame discards the partial accumulation.
    send(0);
    repeat (3) tick();
    send(0);
    reset = 1'b1;
    tick();
    chk("mid_rst_e", e_out, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ev", e_valid, 0);
    reset = 1'b0;
    load_sp(2048);
    frame("post_rst", 2000, 2000, 2000, 2000, 6, 0, -1);
    chk("post_rst_ovr", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
